// File: rtl/sc_pkg.sv
// Shared constants and the controller state encoding for the SC frame sequencing path.
package sc_pkg;
    localparam int N_LOG2      = 3;
    localparam int N           = 2 ** N_LOG2;
    localparam int LLR_W       = 6;
    localparam int FRAME_CNT_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        DECODE,
        OUTPUT
    } state_e;
endpackage

// File: rtl/sc_frame_skid.sv
// Single-entry pending frame buffer: holds one input frame until the controller loads it.
module sc_frame_skid #(
    parameter int W = 48
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] din_i,
    output logic         full_o,
    output logic         ready_o,
    output logic [W-1:0] dout_o
);
    logic         full_q;
    logic [W-1:0] data_q;

    // ready is pure register state so upstream never sees a path from the output side
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else if (push_i && !full_q) begin
            full_q <= 1'b1;
            data_q <= din_i;
        end else if (pop_i) begin
            full_q <= 1'b0;
        end
    end

    assign full_o  = full_q;
    assign ready_o = !full_q;
    assign dout_o  = data_q;
endmodule

// File: rtl/sc_frame_controller.sv
// Sequences LLR frames through the channel register and SC core, with watchdog and
// a valid/ready result port.
module sc_frame_controller
    import sc_pkg::*;
#(
    parameter int n       = N_LOG2,
    parameter int Q       = LLR_W,
    parameter int TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [(2**n)*Q-1:0]      in_llr,
    output logic                     map_valid,
    output logic                     map_busy,
    output logic [(2**n)*Q-1:0]      map_din,
    output logic                     core_start,
    input  logic                     core_done,
    input  logic [(2**n)-1:0]        core_bits,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [(2**n)-1:0]        out_bits,
    output logic                     timeout_err,
    output logic [FRAME_CNT_W-1:0]   frame_cnt
);
    localparam int NB   = 2 ** n;
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    state_e                 state_q, state_d;
    logic [WD_W-1:0]        wd_q, wd_d;
    logic                   out_valid_q, out_valid_d;
    logic [NB-1:0]          out_bits_q, out_bits_d;
    logic                   tmo_q, tmo_d;
    logic [FRAME_CNT_W-1:0] cnt_q, cnt_d;
    logic                   pend_full;

    sc_frame_skid #(.W(NB * Q)) u_skid (
        .clk     (clk),
        .rst     (rst),
        .push_i  (in_valid),
        .pop_i   (state_q == LOAD),
        .din_i   (in_llr),
        .full_o  (pend_full),
        .ready_o (in_ready),
        .dout_o  (map_din)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wd_q        <= '0;
            out_valid_q <= 1'b0;
            out_bits_q  <= '0;
            tmo_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            wd_q        <= wd_d;
            out_valid_q <= out_valid_d;
            out_bits_q  <= out_bits_d;
            tmo_q       <= tmo_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wd_d        = wd_q;
        out_valid_d = out_valid_q;
        out_bits_d  = out_bits_q;
        tmo_d       = tmo_q;
        cnt_d       = cnt_q;
        map_valid   = 1'b0;
        map_busy    = 1'b0;
        core_start  = 1'b0;
        case (state_q)
            IDLE: if (pend_full) state_d = LOAD;
            LOAD: begin
                map_valid = 1'b1;
                state_d   = START;
            end
            START: begin
                core_start = 1'b1;
                map_busy   = 1'b1;
                wd_d       = '0;
                state_d    = DECODE;
            end
            DECODE: begin
                map_busy = 1'b1;
                wd_d     = wd_q + 1'b1;
                // a done arriving on the last allowed cycle still counts as success
                if (core_done) begin
                    out_bits_d  = core_bits;
                    out_valid_d = 1'b1;
                    state_d     = OUTPUT;
                end else if (wd_q == WD_LAST) begin
                    tmo_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            OUTPUT: if (out_ready) begin
                out_valid_d = 1'b0;
                cnt_d       = cnt_q + 1'b1;
                state_d     = pend_full ? LOAD : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign out_valid   = out_valid_q;
    assign out_bits    = out_bits_q;
    assign timeout_err = tmo_q;
    assign frame_cnt   = cnt_q;
endmodule

// File: tb/tb_sc_frame_controller.sv
// Directed bench: default-timeout controller plus a TIMEOUT=4 instance for watchdog cases.
module tb_sc_frame_controller;
    logic        clk;
    logic        rst, in_valid, core_done, out_ready;
    logic [47:0] in_llr;
    logic [7:0]  core_bits;

    logic        in_ready, map_valid, map_busy, core_start, out_valid, timeout_err;
    logic [47:0] map_din;
    logic [7:0]  out_bits;
    logic [15:0] frame_cnt;

    logic        w_in_ready, w_map_valid, w_map_busy, w_core_start, w_out_valid, w_timeout_err;
    logic [47:0] w_map_din;
    logic [7:0]  w_out_bits;
    logic [15:0] w_frame_cnt;

    int vecs = 0;
    int errs = 0;
    logic [47:0] fa, fb, fc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    sc_frame_controller dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_llr(in_llr),
        .map_valid(map_valid), .map_busy(map_busy), .map_din(map_din), .core_start(core_start),
        .core_done(core_done), .core_bits(core_bits), .out_valid(out_valid), .out_ready(out_ready),
        .out_bits(out_bits), .timeout_err(timeout_err), .frame_cnt(frame_cnt)
    );

    sc_frame_controller #(.TIMEOUT(4)) dut_wd (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready), .in_llr(in_llr),
        .map_valid(w_map_valid), .map_busy(w_map_busy), .map_din(w_map_din), .core_start(w_core_start),
        .core_done(core_done), .core_bits(core_bits), .out_valid(w_out_valid), .out_ready(out_ready),
        .out_bits(w_out_bits), .timeout_err(w_timeout_err), .frame_cnt(w_frame_cnt)
    );

    function automatic logic [47:0] mk_frame(int base, int step);
        logic [47:0] f;
        f = '0;
        for (int k = 0; k < 8; k++) f[k*6 +: 6] = 6'(base + k * step);
        return f;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; in_valid = 1'b0; in_llr = '0; core_done = 1'b0; core_bits = '0; out_ready = 1'b0;
        tick; tick;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; in_llr = '0; core_done = 1'b0; core_bits = '0; out_ready = 1'b0;
        tick; tick;
        vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL reset.in_ready got %h want 1", in_ready); end
        vecs++; if (map_valid !== 1'b0) begin errs++; $display("FAIL reset.map_valid got %h want 0", map_valid); end
        vecs++; if (map_busy !== 1'b0) begin errs++; $display("FAIL reset.map_busy got %h want 0", map_busy); end
        vecs++; if (core_start !== 1'b0) begin errs++; $display("FAIL reset.core_start got %h want 0", core_start); end
        vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL reset.out_valid got %h want 0", out_valid); end
        vecs++; if (out_bits !== 8'h00) begin errs++; $display("FAIL reset.out_bits got %h want 00", out_bits); end
        vecs++; if (timeout_err !== 1'b0) begin errs++; $display("FAIL reset.timeout_err got %h want 0", timeout_err); end
        vecs++; if (frame_cnt !== 16'h0) begin errs++; $display("FAIL reset.frame_cnt got %h want 0", frame_cnt); end
        vecs++; if (map_din !== 48'h0) begin errs++; $display("FAIL reset.map_din got %h want 0", map_din); end
        vecs++; if (w_timeout_err !== 1'b0) begin errs++; $display("FAIL reset.w_timeout_err got %h want 0", w_timeout_err); end
    endtask

    task automatic test_single;
        do_reset;
        in_valid = 1'b1; in_llr = fa;
        vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL single.in_ready0 got %h want 1", in_ready); end
        tick;
        in_valid = 1'b0;
        vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL single.in_ready1 got %h want 0", in_ready); end
        vecs++; if (map_valid !== 1'b0) begin errs++; $display("FAIL single.map_valid1 got %h want 0", map_valid); end
        tick;
        vecs++; if (map_valid !== 1'b1) begin errs++; $display("FAIL single.map_valid2 got %h want 1", map_valid); end
        vecs++; if (map_din !== fa) begin errs++; $display("FAIL single.map_din got %h want %h", map_din, fa); end
        vecs++; if (map_busy !== 1'b0) begin errs++; $display("FAIL single.map_busy2 got %h want 0", map_busy); end
        tick;
        vecs++; if (core_start !== 1'b1) begin errs++; $display("FAIL single.core_start3 got %h want 1", core_start); end
        vecs++; if (map_busy !== 1'b1) begin errs++; $display("FAIL single.map_busy3 got %h want 1", map_busy); end
        vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL single.in_ready3 got %h want 1", in_ready); end
        tick;
        for (int i = 0; i < 6; i++) begin
            vecs++; if (map_busy !== 1'b1) begin errs++; $display("FAIL single.map_busy_dec%0d got %h want 1", i, map_busy); end
            vecs++; if (core_start !== 1'b0) begin errs++; $display("FAIL single.core_start_dec%0d got %h want 0", i, core_start); end
            tick;
        end
        core_done = 1'b1; core_bits = 8'hA5;
        tick;
        core_done = 1'b0;
        vecs++; if (out_valid !== 1'b1) begin errs++; $display("FAIL single.out_valid got %h want 1", out_valid); end
        vecs++; if (out_bits !== 8'hA5) begin errs++; $display("FAIL single.out_bits got %h want a5", out_bits); end
        vecs++; if (map_busy !== 1'b0) begin errs++; $display("FAIL single.map_busy_out got %h want 0", map_busy); end
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL single.out_valid_done got %h want 0", out_valid); end
        vecs++; if (frame_cnt !== 16'd1) begin errs++; $display("FAIL single.frame_cnt got %0d want 1", frame_cnt); end
    endtask

    task automatic test_back_to_back;
        do_reset;
        in_valid = 1'b1; in_llr = fa;
        tick;
        in_llr = fb;
        vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL b2b.in_ready1 got %h want 0", in_ready); end
        tick;
        vecs++; if (map_din !== fa) begin errs++; $display("FAIL b2b.map_din_a got %h want %h", map_din, fa); end
        vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL b2b.in_ready2 got %h want 0", in_ready); end
        tick;
        vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL b2b.in_ready3 got %h want 1", in_ready); end
        tick;
        in_valid = 1'b0;
        vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL b2b.in_ready4 got %h want 0", in_ready); end
        vecs++; if (map_din !== fb) begin errs++; $display("FAIL b2b.map_din_pend got %h want %h", map_din, fb); end
        core_done = 1'b1; core_bits = 8'h3C;
        tick;
        core_done = 1'b0;
        vecs++; if (out_bits !== 8'h3C) begin errs++; $display("FAIL b2b.out_bits1 got %h want 3c", out_bits); end
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        vecs++; if (map_valid !== 1'b1) begin errs++; $display("FAIL b2b.load2 got %h want 1", map_valid); end
        vecs++; if (map_din !== fb) begin errs++; $display("FAIL b2b.map_din_b got %h want %h", map_din, fb); end
        vecs++; if (frame_cnt !== 16'd1) begin errs++; $display("FAIL b2b.frame_cnt1 got %0d want 1", frame_cnt); end
        tick;
        vecs++; if (core_start !== 1'b1) begin errs++; $display("FAIL b2b.core_start2 got %h want 1", core_start); end
        tick;
        core_done = 1'b1; core_bits = 8'hC3;
        tick;
        core_done = 1'b0;
        vecs++; if (out_bits !== 8'hC3) begin errs++; $display("FAIL b2b.out_bits2 got %h want c3", out_bits); end
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        vecs++; if (frame_cnt !== 16'd2) begin errs++; $display("FAIL b2b.frame_cnt2 got %0d want 2", frame_cnt); end
    endtask

    task automatic test_stall;
        do_reset;
        in_valid = 1'b1; in_llr = fa;
        tick;
        in_llr = fb;
        tick; tick; tick;
        in_valid = 1'b0;
        core_done = 1'b1; core_bits = 8'h5A;
        tick;
        core_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            vecs++; if (out_valid !== 1'b1) begin errs++; $display("FAIL stall.out_valid%0d got %h want 1", i, out_valid); end
            vecs++; if (out_bits !== 8'h5A) begin errs++; $display("FAIL stall.out_bits%0d got %h want 5a", i, out_bits); end
            vecs++; if (map_valid !== 1'b0) begin errs++; $display("FAIL stall.map_valid%0d got %h want 0", i, map_valid); end
            vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL stall.in_ready%0d got %h want 0", i, in_ready); end
            tick;
        end
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        vecs++; if (map_valid !== 1'b1) begin errs++; $display("FAIL stall.load got %h want 1", map_valid); end
        vecs++; if (map_din !== fb) begin errs++; $display("FAIL stall.map_din got %h want %h", map_din, fb); end
        vecs++; if (frame_cnt !== 16'd1) begin errs++; $display("FAIL stall.frame_cnt got %0d want 1", frame_cnt); end
    endtask

    task automatic test_watchdog;
        do_reset;
        in_valid = 1'b1; in_llr = fa;
        tick;
        in_valid = 1'b0;
        tick; tick;
        vecs++; if (w_core_start !== 1'b1) begin errs++; $display("FAIL wd.core_start got %h want 1", w_core_start); end
        tick;
        for (int i = 0; i < 4; i++) begin
            vecs++; if (w_map_busy !== 1'b1) begin errs++; $display("FAIL wd.busy%0d got %h want 1", i, w_map_busy); end
            vecs++; if (w_timeout_err !== 1'b0) begin errs++; $display("FAIL wd.err_early%0d got %h want 0", i, w_timeout_err); end
            tick;
        end
        vecs++; if (w_map_busy !== 1'b0) begin errs++; $display("FAIL wd.busy_after got %h want 0", w_map_busy); end
        vecs++; if (w_timeout_err !== 1'b1) begin errs++; $display("FAIL wd.timeout_err got %h want 1", w_timeout_err); end
        vecs++; if (w_out_valid !== 1'b0) begin errs++; $display("FAIL wd.out_valid got %h want 0", w_out_valid); end
        vecs++; if (w_frame_cnt !== 16'd0) begin errs++; $display("FAIL wd.frame_cnt got %0d want 0", w_frame_cnt); end
        vecs++; if (w_in_ready !== 1'b1) begin errs++; $display("FAIL wd.in_ready got %h want 1", w_in_ready); end
        in_valid = 1'b1; in_llr = fb;
        tick;
        in_valid = 1'b0;
        tick;
        vecs++; if (w_map_valid !== 1'b1) begin errs++; $display("FAIL wd.load2 got %h want 1", w_map_valid); end
        vecs++; if (w_map_din !== fb) begin errs++; $display("FAIL wd.map_din2 got %h want %h", w_map_din, fb); end
        tick; tick;
        core_done = 1'b1; core_bits = 8'h99;
        tick;
        core_done = 1'b0;
        vecs++; if (w_out_valid !== 1'b1) begin errs++; $display("FAIL wd.out_valid2 got %h want 1", w_out_valid); end
        vecs++; if (w_out_bits !== 8'h99) begin errs++; $display("FAIL wd.out_bits2 got %h want 99", w_out_bits); end
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        vecs++; if (w_frame_cnt !== 16'd1) begin errs++; $display("FAIL wd.frame_cnt2 got %0d want 1", w_frame_cnt); end
        vecs++; if (w_timeout_err !== 1'b1) begin errs++; $display("FAIL wd.err_sticky got %h want 1", w_timeout_err); end
    endtask

    task automatic test_collision;
        do_reset;
        in_valid = 1'b1; in_llr = fa;
        tick;
        in_valid = 1'b0;
        repeat (6) tick;
        core_done = 1'b1; core_bits = 8'h77;
        tick;
        core_done = 1'b0;
        vecs++; if (w_out_valid !== 1'b1) begin errs++; $display("FAIL coll.out_valid got %h want 1", w_out_valid); end
        vecs++; if (w_out_bits !== 8'h77) begin errs++; $display("FAIL coll.out_bits got %h want 77", w_out_bits); end
        vecs++; if (w_timeout_err !== 1'b0) begin errs++; $display("FAIL coll.timeout_err got %h want 0", w_timeout_err); end
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        vecs++; if (w_frame_cnt !== 16'd1) begin errs++; $display("FAIL coll.frame_cnt got %0d want 1", w_frame_cnt); end
    endtask

    task automatic test_reset_mid;
        do_reset;
        in_valid = 1'b1; in_llr = fa;
        tick;
        in_llr = fb;
        tick; tick; tick;
        in_valid = 1'b0;
        core_done = 1'b1; core_bits = 8'h11;
        tick;
        core_done = 1'b0; out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        vecs++; if (frame_cnt !== 16'd1) begin errs++; $display("FAIL rmid.frame_cnt_pre got %0d want 1", frame_cnt); end
        in_valid = 1'b1; in_llr = fc;
        tick; tick;
        in_valid = 1'b0;
        repeat (4) tick;
        vecs++; if (map_busy !== 1'b1) begin errs++; $display("FAIL rmid.busy_pre got %h want 1", map_busy); end
        vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL rmid.in_ready_pre got %h want 0", in_ready); end
        vecs++; if (map_din !== fc) begin errs++; $display("FAIL rmid.map_din_pre got %h want %h", map_din, fc); end
        vecs++; if (w_timeout_err !== 1'b1) begin errs++; $display("FAIL rmid.w_err_pre got %h want 1", w_timeout_err); end
        #1 rst = 1'b1;
        #1;
        vecs++; if (map_busy !== 1'b0) begin errs++; $display("FAIL rmid.busy_rst got %h want 0", map_busy); end
        vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL rmid.in_ready_rst got %h want 1", in_ready); end
        vecs++; if (frame_cnt !== 16'd0) begin errs++; $display("FAIL rmid.frame_cnt_rst got %0d want 0", frame_cnt); end
        vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL rmid.out_valid_rst got %h want 0", out_valid); end
        vecs++; if (map_din !== 48'h0) begin errs++; $display("FAIL rmid.map_din_rst got %h want 0", map_din); end
        vecs++; if (w_timeout_err !== 1'b0) begin errs++; $display("FAIL rmid.w_err_rst got %h want 0", w_timeout_err); end
        tick;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vecs++; if (map_valid !== 1'b0) begin errs++; $display("FAIL rmid.map_valid_post%0d got %h want 0", i, map_valid); end
            vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL rmid.in_ready_post%0d got %h want 1", i, in_ready); end
            tick;
        end
    endtask

    initial begin
        fa = mk_frame(0, 1);
        fb = mk_frame(40, 3);
        fc = mk_frame(63, -5);
        test_reset;
        test_single;
        test_back_to_back;
        test_stall;
        test_watchdog;
        test_collision;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/sc_frame_controller.md
Name: sc_frame_controller

Overview:
- Sequences LLR frames from the channel interface into the bit-reversed channel register and through the SC decoder core.
- Holds one pending input frame in a skid buffer so the next frame can arrive while the current one decodes.
- Drives the mapping block's data_valid/decoder_busy, pulses core start, watches for done with a watchdog, and hands decoded bits out over a valid/ready port.

Parameters:
- n, 3, log2 of code length N = 2**n
- Q, 6, LLR width in bits
- TIMEOUT, 255, maximum cycles allowed in DECODE before abort (must be >= 1)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input frame valid
- in_ready  out  1  controller can accept a frame
- in_llr  in  N*Q  natural-order LLRs, LLR k at [k*Q+:Q]
- map_valid  out  1  to mapping block data_valid
- map_busy  out  1  to mapping block decoder_busy
- map_din  out  N*Q  to mapping block din
- core_start  out  1  one-cycle start pulse to SC core
- core_done  in  1  SC core finished, core_bits valid this cycle
- core_bits  in  N  decoded bits from core
- out_valid  out  1  decoded frame available
- out_ready  in  1  downstream accepts frame
- out_bits  out  N  decoded bits, held while out_valid
- timeout_err  out  1  sticky watchdog abort flag
- frame_cnt  out  16  count of frames delivered, wraps

Behaviour:
- Reset (async, rst=1): FSM to IDLE. pend_full=0, pend_data=0, out_valid=0, out_bits=0, timeout_err=0, frame_cnt=0, watchdog=0, core_start=0, map_valid=0, map_busy=0. A pending or in-flight frame is dropped. Outputs hold reset values while rst=1.
- Pending buffer: in_ready = !pend_full (registered state, no combinational path from out_ready).
  - Accept on in_valid && in_ready: pend_data <= in_llr, pend_full <= 1.
  - pend_full clears at the end of the LOAD cycle, so in_ready rises the next cycle.
- map_din = pend_data at all times.
- FSM states and transitions:
  - IDLE: if pend_full, go to LOAD.
  - LOAD (1 cycle): map_valid=1, map_busy=0. Go to START.
  - START (1 cycle): core_start=1, map_busy=1, watchdog <= 0. Go to DECODE. core_done here is ignored.
  - DECODE: map_busy=1, watchdog increments each cycle.
    - On core_done: out_bits <= core_bits, out_valid <= 1, go to OUTPUT.
    - Otherwise, if watchdog == TIMEOUT-1: timeout_err <= 1, go to IDLE, no output.
    - core_done in the same cycle as timeout: done wins, timeout_err stays unchanged.
  - OUTPUT: map_busy=0, out_valid=1, out_bits stable.
    - On out_ready: out_valid <= 0, frame_cnt <= frame_cnt+1, then LOAD if pend_full else IDLE.
- map_valid is 1 only in LOAD; core_start is 1 only in START. Both are Moore outputs.
- Latency: frame accepted at cycle t gives LOAD at t+2, START at t+3, first DECODE cycle at t+4. Core done at cycle d gives out_valid at d+1.
- Back-to-back: a second frame may be accepted from LOAD+1 onward. It waits in the buffer until OUTPUT completes, so no overwrite is possible.
- Widths: watchdog is $clog2(TIMEOUT+1) bits. frame_cnt wraps from 0xFFFF to 0. timeout_err clears only on rst.

Decomposition:
- Shared package sc_pkg: N = 2**n, LLR_W = Q, state enum {IDLE, LOAD, START, DECODE, OUTPUT}, frame_cnt width constant 16.
- One natural sub-module: sc_frame_skid, the single-entry pending buffer (data register, full flag, ready logic).
- FSM, watchdog and output register stay in the top level.

Test Plan:
- Single frame: in_llr = LLRs 0..7 (Q=6), in_valid for 1 cycle at t=0 -> map_valid=1 at t=2 with map_din equal to the input, core_start at t=3, map_busy=1 t=3..done. Model core_done at t=10 with core_bits=8'hA5 -> out_valid at t=11, out_bits=A5; out_ready=1 -> frame_cnt=1.
- Back-to-back: two frames offered continuously -> second accepted at LOAD+1 (in_ready rises t=3). Second LOAD occurs the cycle after the first out handshake, with map_din equal to the second frame. frame_cnt=2 at end.
- Output stall: out_ready=0 for 20 cycles -> out_valid and out_bits stable, map_valid stays 0, pending frame is not loaded, in_ready=0 while the buffer is full.
- Watchdog: TIMEOUT=4, core_done never asserted -> exactly 4 DECODE cycles, then IDLE, timeout_err=1, out_valid=0, frame_cnt unchanged. A next frame proceeds normally with timeout_err still 1.
- Done/timeout collision: TIMEOUT=4, core_done on the 4th DECODE cycle -> out_valid=1, timeout_err=0.
- Reset mid-decode: rst=1 in DECODE with a pending frame -> all outputs reset immediately (async), in_ready=1 after release, frame_cnt=0, pending frame dropped.
